// File: rtl/gate_resp_misr_pkg.sv
// Shared definitions for the gate-model response compactor family.
// Response bit order for the 12-in/10-out gate model, bit 9 down to bit 0:
//   N501, N511, N503, N490, N509, N510, N496, N508, N495, N512
package gate_resp_misr_pkg;

  localparam int unsigned RESP_W = 10;
  localparam int unsigned SIG_W  = 16;
  localparam int unsigned CNT_W  = 16;

  // Feedback taps; the x^16 term is implicit in the shift-out bit.
  localparam logic [SIG_W-1:0] POLY = 16'h002D;

  // Encoding 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/gate_resp_misr_misr_step.sv
// One MISR step: shift, fold the feedback polynomial, xor in the response.
module gate_resp_misr_misr_step
  import gate_resp_misr_pkg::*;
(
  input  logic [SIG_W-1:0]  signature,
  input  logic [RESP_W-1:0] resp_data,
  output logic [SIG_W-1:0]  sig_next_c
);

  // Pure combinational next-signature.
  always_comb begin
    sig_next_c = {signature[SIG_W-2:0], 1'b0}
               ^ (signature[SIG_W-1] ? POLY : SIG_W'(0))
               ^ SIG_W'(resp_data);
  end

endmodule

// File: rtl/gate_resp_misr.sv
// Response compactor: folds gate-model outputs into a MISR over a programmed
// number of patterns, then reports the signature and a pass/fail compare.
module gate_resp_misr
  import gate_resp_misr_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  pattern_count,
  input  logic [SIG_W-1:0]  seed,
  input  logic [SIG_W-1:0]  expected,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp_data,
  output logic              resp_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  captured
);

  state_e             state_q, state_d;
  logic [SIG_W-1:0]   sig_q, sig_d;
  logic [CNT_W-1:0]   cap_q, cap_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SIG_W-1:0]   exp_q, exp_d;
  logic               pass_q, pass_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;

  logic [SIG_W-1:0]   sig_next_c;
  logic [CNT_W-1:0]   cap_inc_c;
  logic               xfer_c;

  gate_resp_misr_misr_step u_misr_step (
    .signature  (sig_q),
    .resp_data  (resp_data),
    .sig_next_c (sig_next_c)
  );

  // Next-state, datapath and output decode.
  always_comb begin
    state_d   = state_q;
    sig_d     = sig_q;
    cap_d     = cap_q;
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    pass_d    = pass_q;
    xfer_c    = resp_valid && (state_q == ST_RUN);
    cap_inc_c = cap_q + CNT_W'(1);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if ((state_q == ST_DONE) && abort) begin
          state_d = ST_IDLE;
          pass_d  = 1'b0;
        end else if (start) begin
          sig_d  = seed;
          cap_d  = '0;
          cnt_d  = pattern_count;
          exp_d  = expected;
          pass_d = 1'b0;
          if (pattern_count == '0) begin
            state_d = ST_DONE;
            pass_d  = (seed == expected);
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // Abort wins over a simultaneous transfer, which is dropped.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (xfer_c) begin
          sig_d = sig_next_c;
          cap_d = cap_inc_c;
          if (cap_inc_c == cnt_q) begin
            state_d = ST_DONE;
            pass_d  = (sig_next_c == exp_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status flags are registered copies of the next state's decode.
    busy_d  = (state_d == ST_RUN);
    ready_d = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sig_q   <= '0;
      cap_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign resp_ready = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign signature  = sig_q;
  assign captured   = cap_q;

endmodule

// File: tb/tb_gate_resp_misr.sv
// Self-checking bench for gate_resp_misr with a behavioural signature model.
module tb_gate_resp_misr;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] pattern_count;
  logic [15:0] seed;
  logic [15:0] expected;
  logic        resp_valid;
  logic [9:0]  resp_data;
  logic        resp_ready;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;
  logic [15:0] captured;

  int errors = 0;
  int checks = 0;

  gate_resp_misr dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .pattern_count (pattern_count),
    .seed          (seed),
    .expected      (expected),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .resp_ready    (resp_ready),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .signature     (signature),
    .captured      (captured)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Polynomial-division view of one step: multiply by x, reduce mod x^16+POLY, add r.
  function automatic logic [15:0] model_step(input logic [15:0] s, input logic [9:0] r);
    int unsigned v;
    v = (int'(s) * 2) % 65536;
    if (int'(s) >= 32768) v = v ^ 32'h2D;
    v = v ^ int'(r);
    return 16'(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] cnt, input logic [15:0] sd, input logic [15:0] ex);
    pattern_count = cnt;
    seed          = sd;
    expected      = ex;
    start         = 1'b1;
    step();
    start         = 1'b0;
    pattern_count = 16'($urandom);
    seed          = 16'($urandom);
    expected      = 16'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({busy, resp_ready, done, pass, signature, captured} !== 36'h0) begin
      errors++;
      $display("FAIL reset_outputs: got b=%0b r=%0b d=%0b p=%0b sig=%h cap=%0d want all 0",
               busy, resp_ready, done, pass, signature, captured);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    do_start(16'd2, 16'h0000, 16'h07FF);
    checks++;
    if ({busy, resp_ready, done} !== 3'b110) begin
      errors++;
      $display("FAIL basic_start_flags: got b/r/d=%b want 110", {busy, resp_ready, done});
    end
    resp_valid = 1'b1;
    resp_data  = 10'h3FF;
    step();
    checks++;
    if (signature !== 16'h03FF || captured !== 16'd1) begin
      errors++;
      $display("FAIL basic_first: got sig=%h cap=%0d want 03ff 1", signature, captured);
    end
    resp_data = 10'h001;
    step();
    resp_valid = 1'b0;
    checks++;
    if (signature !== 16'h07FF || captured !== 16'd2 || {done, pass, busy, resp_ready} !== 4'b1100) begin
      errors++;
      $display("FAIL basic_final: got sig=%h cap=%0d d/p/b/r=%b want 07ff 2 1100",
               signature, captured, {done, pass, busy, resp_ready});
    end
  endtask

  task automatic test_feedback();
    for (int k = 0; k < 2; k++) begin
      logic [15:0] ex;
      ex = (k == 0) ? 16'h002D : 16'h0000;
      do_start(16'd1, 16'h8000, ex);
      resp_valid = 1'b1;
      resp_data  = 10'h000;
      step();
      resp_valid = 1'b0;
      checks++;
      if (signature !== 16'h002D || done !== 1'b1 || pass !== (k == 0)) begin
        errors++;
        $display("FAIL feedback_%0d: got sig=%h d=%0b p=%0b want 002d 1 %0b",
                 k, signature, done, pass, (k == 0));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] ms;
    int          n;
    ms = 16'($urandom);
    n  = 0;
    do_start(16'd3, ms, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      resp_valid = (i % 2 == 0);
      resp_data  = 10'($urandom);
      if (resp_valid) begin
        ms = model_step(ms, resp_data);
        n++;
      end
      step();
      checks++;
      if (captured !== 16'(n) || signature !== ms || done !== (n == 3)) begin
        errors++;
        $display("FAIL backpressure_c%0d: got cap=%0d sig=%h d=%0b want %0d %h %0b",
                 i, captured, signature, done, n, ms, (n == 3));
      end
    end
    resp_valid = 1'b1;
    resp_data  = 10'h155;
    step();
    resp_valid = 1'b0;
    checks++;
    if (resp_ready !== 1'b0 || captured !== 16'd3 || signature !== ms || done !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_done_hold: got r=%0b cap=%0d sig=%h d=%0b want 0 3 %h 1",
               resp_ready, captured, signature, done, ms);
    end
  endtask

  task automatic test_zero_count();
    int ready_seen;
    ready_seen = 0;
    resp_valid = 1'b1;
    do_start(16'd0, 16'h1234, 16'h1234);
    checks++;
    if ({done, pass} !== 2'b11 || captured !== 16'd0 || signature !== 16'h1234) begin
      errors++;
      $display("FAIL zero_count: got d/p=%b cap=%0d sig=%h want 11 0 1234",
               {done, pass}, captured, signature);
    end
    for (int i = 0; i < 4; i++) begin
      if (resp_ready) ready_seen++;
      step();
    end
    resp_valid = 1'b0;
    checks++;
    if (ready_seen != 0 || captured !== 16'd0) begin
      errors++;
      $display("FAIL zero_ready: got ready_cycles=%0d cap=%0d want 0 0", ready_seen, captured);
    end
  endtask

  task automatic test_abort_restart();
    logic [15:0] ms;
    logic [15:0] sd;
    ms = 16'hBEEF;
    do_start(16'd4, ms, 16'h0000);
    resp_valid = 1'b1;
    resp_data  = 10'($urandom);
    ms = model_step(ms, resp_data);
    step();
    resp_valid = 1'b0;
    // start during RUN must not reload anything
    pattern_count = 16'd1;
    seed          = 16'h0F0F;
    start         = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || captured !== 16'd1 || signature !== ms) begin
      errors++;
      $display("FAIL start_in_run: got b=%0b cap=%0d sig=%h want 1 1 %h", busy, captured, signature, ms);
    end
    abort      = 1'b1;
    resp_valid = 1'b1;
    resp_data  = 10'h2AA;
    step();
    abort      = 1'b0;
    resp_valid = 1'b0;
    checks++;
    if ({busy, resp_ready, done, pass} !== 4'b0000 || captured !== 16'd1 || signature !== ms) begin
      errors++;
      $display("FAIL abort: got b/r/d/p=%b cap=%0d sig=%h want 0000 1 %h",
               {busy, resp_ready, done, pass}, captured, signature, ms);
    end
    step();
    sd = 16'($urandom);
    ms = sd;
    begin
      logic [9:0] d [4];
      for (int i = 0; i < 4; i++) begin
        d[i] = 10'($urandom);
        ms   = model_step(ms, d[i]);
      end
      do_start(16'd4, sd, ms);
      checks++;
      if (signature !== sd || captured !== 16'd0) begin
        errors++;
        $display("FAIL restart_load: got sig=%h cap=%0d want %h 0", signature, captured, sd);
      end
      for (int i = 0; i < 4; i++) begin
        resp_valid = 1'b1;
        resp_data  = d[i];
        step();
      end
      resp_valid = 1'b0;
    end
    checks++;
    if (signature !== ms || captured !== 16'd4 || {done, pass} !== 2'b11) begin
      errors++;
      $display("FAIL restart_final: got sig=%h cap=%0d d/p=%b want %h 4 11",
               signature, captured, {done, pass}, ms);
    end
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 8; r++) begin
      int          cnt;
      int          k;
      int          cyc;
      logic [15:0] sd;
      logic [15:0] ms;
      logic [15:0] ex;
      logic        want_pass;
      logic [9:0]  d [$];
      cnt = $urandom_range(1, 9);
      sd  = 16'($urandom);
      ms  = sd;
      d.delete();
      for (int i = 0; i < cnt; i++) begin
        d.push_back(10'($urandom));
        ms = model_step(ms, d[i]);
      end
      want_pass = ($urandom_range(0, 1) == 1);
      ex = want_pass ? ms : (ms ^ 16'(1 << $urandom_range(0, 15)));
      do_start(16'(cnt), sd, ex);
      k   = 0;
      cyc = 0;
      while (!done && cyc < 200) begin
        resp_valid = ($urandom_range(0, 3) != 0);
        resp_data  = resp_valid ? d[k] : 10'($urandom);
        step();
        if (resp_valid) k++;
        cyc++;
      end
      resp_valid = 1'b0;
      checks++;
      if (done !== 1'b1 || k != cnt || signature !== ms || captured !== 16'(cnt) || pass !== want_pass) begin
        errors++;
        $display("FAIL random_run%0d: got d=%0b xfers=%0d sig=%h cap=%0d p=%0b want 1 %0d %h %0d %0b",
                 r, done, k, signature, captured, pass, cnt, ms, cnt, want_pass);
      end
    end
  endtask

  task automatic test_reset_midrun();
    do_start(16'd4, 16'h5A5A, 16'h0000);
    resp_valid = 1'b1;
    resp_data  = 10'h0F3;
    step();
    step();
    resp_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, resp_ready, done, pass, signature, captured} !== 36'h0) begin
      errors++;
      $display("FAIL reset_midrun: got b=%0b r=%0b d=%0b p=%0b sig=%h cap=%0d want all 0",
               busy, resp_ready, done, pass, signature, captured);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    test_basic();
  endtask

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    pattern_count = '0;
    seed          = '0;
    expected      = '0;
    resp_valid    = 1'b0;
    resp_data     = '0;
    test_reset();
    test_basic();
    test_feedback();
    test_backpressure();
    test_zero_count();
    test_abort_restart();
    test_random_runs();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
